line_burst_responder: RTL and testbench
=======================================

Name: line_burst_responder

Overview:
- Memory-side responder for the L1 cache line interface (read/write strobe, 32-bit address, 256-bit line data, single-cycle resp).
- Converts each line request into a fixed-length burst on the 64-bit physical memory bus. For reads it assembles the line; for writes it serializes the line.
- Sits between an icache/dcache (or the arbiter in front of them) and physical memory.

Parameters:
S_LINE, 256, line width in bits
S_BEAT, 64, physical memory beat width in bits
S_ADDR, 32, address width
S_OFF, 5, line offset bits; the line address is aligned by zeroing these
BEATS, S_LINE/S_BEAT (=4), beats per burst (derived, not overridable)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  synchronous reset, active low
line_read_i  in  1  cache requests a line read; held until line_resp_o
line_write_i  in  1  cache requests a line writeback; held until line_resp_o
line_addr_i  in  S_ADDR  requested line address (low S_OFF bits ignored)
line_wdata_i  in  S_LINE  writeback line data
line_rdata_o  out  S_LINE  assembled read line
line_resp_o  out  1  single-cycle completion pulse
pmem_read_o  out  1  burst read request to physical memory
pmem_write_o  out  1  burst write request to physical memory
pmem_addr_o  out  S_ADDR  line-aligned burst address
pmem_wdata_o  out  S_BEAT  current write beat
pmem_rdata_i  in  S_BEAT  current read beat
pmem_resp_i  in  1  one pulse per completed beat

Behaviour:
- Reset, sampled when rst_n=0 at a clk edge:
  - state=IDLE, beat count=0, line_rdata_o=0, pmem_addr_o=0.
  - pmem_read_o, pmem_write_o and line_resp_o are all 0.
  - Applies mid-burst: the burst is abandoned, no resp is issued and the partial line is discarded.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - line_read_i=1 → latch {line_addr_i[S_ADDR-1:S_OFF], S_OFF'b0} into the address register and clear beat count; go to RD_BURST.
  - Else line_write_i=1 → also latch line_wdata_i into the write buffer; go to WR_BURST.
  - Read wins when both strobes are asserted.
- RD_BURST:
  - pmem_read_o=1 and pmem_addr_o = latched address, both stable for the whole burst.
  - On each pmem_resp_i: store pmem_rdata_i into line buffer bits [S_BEAT*k +: S_BEAT], where k is the beat count, then increment k.
  - On the resp with k=BEATS-1 → DONE. pmem_read_o drops in DONE.
- WR_BURST:
  - pmem_write_o=1 and pmem_wdata_o = write buffer [S_BEAT*k +: S_BEAT].
  - Increment k on each pmem_resp_i.
  - On the resp with k=BEATS-1 → DONE.
- DONE:
  - line_resp_o=1 for exactly this one cycle.
  - line_rdata_o holds the full assembled line and stays stable until the last beat of the next read burst.
  - Next state is always IDLE; request strobes are ignored in DONE.
  - This one-cycle gap is mandatory: the cache's miss signal may still be high in the cycle after resp.
- Latency:
  - Request seen in IDLE at cycle 0 → pmem strobe asserted at cycle 1.
  - With memory returning one beat per cycle, the last beat is at cycle 4 and line_resp_o at cycle 5.
  - Zero-wait-state minimum request-to-resp is BEATS+1 cycles.
- pmem_resp_i outside RD_BURST/WR_BURST is ignored.
- Beat counter: 2 bits (log2 BEATS). It wraps to 0 only via IDLE re-entry, never inside a burst.
- Request strobes dropping mid-burst are a protocol error. The burst completes regardless and resp is still pulsed.
- Write path never modifies line_rdata_o.

Decomposition:
- Shared package (cache_types_pkg):
  - state enum (IDLE, RD_BURST, WR_BURST, DONE).
  - S_LINE/S_BEAT/S_OFF constants.
  - BEATS and beat-count width, derived as constants.
- One sub-module, burst_shift_buffer, holds the S_LINE-bit buffer with per-beat write-enable (read assembly) and indexed beat select (write serialization).
- The FSM and address register stay in the top module.

Test Plan:
- Read, zero wait:
  - Stimulus: line_read_i=1, addr=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - Response: pmem_addr_o=0x0000_1220; line_rdata_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; line_resp_o high exactly at cycle 5.
- Write with waits:
  - Stimulus: line_write_i=1, wdata={D3,D2,D1,D0}; pmem_resp_i every 3rd cycle.
  - Response: pmem_wdata_o steps D0→D1→D2→D3, each held until its resp; one line_resp_o pulse; line_rdata_o unchanged.
- Held request after resp:
  - Stimulus: line_read_i stays 1 through DONE and for one cycle after.
  - Response: no new burst starts in DONE; a second burst starts from IDLE only at the cycle after DONE.
- Simultaneous strobes:
  - Stimulus: line_read_i=1 and line_write_i=1 at addr 0x8000_0040.
  - Response: pmem_read_o=1, pmem_write_o=0.
- Reset mid-burst:
  - Stimulus: rst_n=0 after 2 read beats.
  - Response: next cycle all strobes=0 and line_rdata_o=0; a following read assembles a fresh line with no stale beats.
- Stray resp:
  - Stimulus: pmem_resp_i pulses in IDLE.
  - Response: no state change, no line_resp_o.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types and sizing for the line burst responder.
// A cache line (S_LINE bits) moves to and from physical memory as a burst of
// BEATS transfers of S_BEAT bits each. BEATS and the beat counter width are
// derived from the line and beat widths and cannot be overridden on their own.
package cache_types_pkg;

  localparam int S_LINE = 256;
  localparam int S_BEAT = 64;
  localparam int S_ADDR = 32;
  localparam int S_OFF  = 5;
  localparam int BEATS  = S_LINE / S_BEAT;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Clear the line-offset bits to get the burst base address.
  function automatic logic [S_ADDR-1:0] line_align(input logic [S_ADDR-1:0] a);
    return a & ~((S_ADDR'(1) << S_OFF) - S_ADDR'(1));
  endfunction

endpackage

// File: rtl/burst_shift_buffer.sv
// Line-wide staging buffer shared by both burst directions.
// Reads: one beat at a time is written at beat_idx_i (line assembly).
// Writes: the whole line is loaded once, then beat_o presents the beat at
// beat_idx_i (line serialization).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears the buffer)
//   load_i       load the full line from load_data_i (wins over beat_we_i)
//   beat_we_i    write beat_data_i into beat slot beat_idx_i
//   beat_idx_i   beat slot for both the beat write and beat_o
//   line_o       current buffer contents
//   beat_o       beat slot beat_idx_i of the current contents
module burst_shift_buffer
  import cache_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [S_LINE-1:0] load_data_i,
  input  logic              beat_we_i,
  input  logic [CNT_W-1:0]  beat_idx_i,
  input  logic [S_BEAT-1:0] beat_data_i,
  output logic [S_LINE-1:0] line_o,
  output logic [S_BEAT-1:0] beat_o
);

  logic [BEATS-1:0][S_BEAT-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_i)         data_d = load_data_i;
    else if (beat_we_i) data_d[beat_idx_i] = beat_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign line_o = data_q;
  assign beat_o = data_q[beat_idx_i];

endmodule

// File: rtl/line_burst_responder.sv
// Memory-side responder for the L1 cache line interface. Each line request
// becomes a BEATS-long burst on the S_BEAT-wide physical memory bus; reads
// are assembled into a line, writebacks are serialized beat by beat.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   line_read_i/line_write_i   cache line read / writeback request (held)
//   line_addr_i, line_wdata_i  request address and writeback line
//   line_rdata_o, line_resp_o  assembled read line, one-cycle completion
//   pmem_read_o/pmem_write_o   burst strobes to physical memory
//   pmem_addr_o, pmem_wdata_o  line-aligned burst address, current write beat
//   pmem_rdata_i, pmem_resp_i  current read beat, per-beat completion pulse
module line_burst_responder
  import cache_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [S_ADDR-1:0] line_addr_i,
  input  logic [S_LINE-1:0] line_wdata_i,
  output logic [S_LINE-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic              pmem_read_o,
  output logic              pmem_write_o,
  output logic [S_ADDR-1:0] pmem_addr_o,
  output logic [S_BEAT-1:0] pmem_wdata_o,
  input  logic [S_BEAT-1:0] pmem_rdata_i,
  input  logic              pmem_resp_i
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [S_ADDR-1:0] addr_q, addr_d;
  logic [S_LINE-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d, wr_q, wr_d, resp_q, resp_d;

  logic              load_wbuf, beat_we, last_beat;
  logic [S_LINE-1:0] buf_line, asm_line;
  logic [S_BEAT-1:0] buf_beat;

  assign last_beat = pmem_resp_i && (cnt_q == CNT_W'(BEATS-1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    resp_d    = 1'b0;
    load_wbuf = 1'b0;
    beat_we   = 1'b0;
    // Full line as it will look once the final beat lands; the visible
    // read line only changes here so it stays stable across the burst.
    asm_line  = buf_line;
    asm_line[S_LINE-S_BEAT +: S_BEAT] = pmem_rdata_i;

    unique case (state_q)
      IDLE: begin
        if (line_read_i) begin
          state_d = RD_BURST;
          addr_d  = line_align(line_addr_i);
          cnt_d   = '0;
          rd_d    = 1'b1;
        end else if (line_write_i) begin
          state_d   = WR_BURST;
          addr_d    = line_align(line_addr_i);
          cnt_d     = '0;
          wr_d      = 1'b1;
          load_wbuf = 1'b1;
        end
      end
      RD_BURST: begin
        if (pmem_resp_i) begin
          beat_we = 1'b1;
          if (last_beat) begin
            state_d = DONE;
            rd_d    = 1'b0;
            resp_d  = 1'b1;
            rdata_d = asm_line;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (pmem_resp_i) begin
          if (last_beat) begin
            state_d = DONE;
            wr_d    = 1'b0;
            resp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // One dead cycle: the cache may still show its request right after resp.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
    end
  end

  burst_shift_buffer u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_wbuf),
    .load_data_i (line_wdata_i),
    .beat_we_i   (beat_we),
    .beat_idx_i  (cnt_q),
    .beat_data_i (pmem_rdata_i),
    .line_o      (buf_line),
    .beat_o      (buf_beat)
  );

  assign line_rdata_o = rdata_q;
  assign line_resp_o  = resp_q;
  assign pmem_read_o  = rd_q;
  assign pmem_write_o = wr_q;
  assign pmem_addr_o  = addr_q;
  assign pmem_wdata_o = buf_beat;

endmodule

// File: tb/tb_line_burst_responder.sv
// Self-checking bench: randomized and directed line requests against a
// transaction-level model of the responder; memory side is a bench process
// with configurable wait patterns.
module tb_line_burst_responder;
  import cache_types_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         line_read_i, line_write_i;
  logic [31:0]  line_addr_i;
  logic [255:0] line_wdata_i, line_rdata_o;
  logic         line_resp_o, pmem_read_o, pmem_write_o;
  logic [31:0]  pmem_addr_o;
  logic [63:0]  pmem_wdata_o, pmem_rdata_i;
  logic         pmem_resp_i;

  always #5 clk = ~clk;

  line_burst_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_addr_i  (line_addr_i),
    .line_wdata_i (line_wdata_i),
    .line_rdata_o (line_rdata_o),
    .line_resp_o  (line_resp_o),
    .pmem_read_o  (pmem_read_o),
    .pmem_write_o (pmem_write_o),
    .pmem_addr_o  (pmem_addr_o),
    .pmem_wdata_o (pmem_wdata_o),
    .pmem_rdata_i (pmem_rdata_i),
    .pmem_resp_i  (pmem_resp_i)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- memory side ----------------
  int wait_n = 0;    // 0: every cycle, N>0: every Nth cycle, -1: random
  bit pat    = 1'b0; // read beats k = {8{0x11*(k+1)}}
  bit stray  = 1'b0; // random resp pulses while no burst is requested
  int mem_k  = 0, gap = 0;
  bit go;

  initial forever begin
    @(negedge clk);
    if (pmem_read_o === 1'b1 || pmem_write_o === 1'b1) begin
      gap++;
      if (wait_n == 0)     go = 1'b1;
      else if (wait_n < 0) go = 1'($urandom_range(0, 1));
      else                 go = (gap % wait_n == 0);
      pmem_resp_i  = go;
      pmem_rdata_i = pat ? {8{8'(8'h11 * (mem_k + 1))}} : {$urandom, $urandom};
      if (go) mem_k++;
    end else begin
      gap = 0;
      mem_k = 0;
      pmem_resp_i  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      pmem_rdata_i = {$urandom, $urandom};
    end
  end

  // ---------------- transaction-level model ----------------
  bit           m_valid = 1'b0, m_rd = 1'b0, m_wr = 1'b0, m_done = 1'b0;
  int           m_cnt = 0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_wbuf = '0, m_line = '0;
  logic [63:0]  m_beats [4];

  task automatic model_step();
    if (!rst_n) begin
      m_valid = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_done = 1'b0;
      m_cnt = 0; m_addr = '0; m_line = '0;
    end else if (m_valid) begin
      if (m_done) m_done = 1'b0;
      else if (m_rd || m_wr) begin
        if (pmem_resp_i === 1'b1) begin
          if (m_rd) m_beats[m_cnt] = pmem_rdata_i;
          m_cnt++;
          if (m_cnt == 4) begin
            if (m_rd) for (int i = 0; i < 4; i++) m_line[64*i +: 64] = m_beats[i];
            m_rd = 1'b0; m_wr = 1'b0; m_done = 1'b1;
          end
        end
      end else if (line_read_i) begin
        m_rd = 1'b1; m_cnt = 0; m_addr = {line_addr_i[31:5], 5'b0};
      end else if (line_write_i) begin
        m_wr = 1'b1; m_cnt = 0; m_addr = {line_addr_i[31:5], 5'b0}; m_wbuf = line_wdata_i;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("pmem_read",  256'(pmem_read_o),  256'(m_rd));
      chk("pmem_write", 256'(pmem_write_o), 256'(m_wr));
      chk("line_resp",  256'(line_resp_o),  256'(m_done));
      chk("line_rdata", line_rdata_o, m_line);
      chk("pmem_addr",  256'(pmem_addr_o),  256'(m_addr));
      if (m_wr) chk("pmem_wdata", 256'(pmem_wdata_o), 256'(m_wbuf[64*m_cnt +: 64]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [255:0] d, input bit hold, output int lat);
    line_read_i = rd; line_write_i = wr; line_addr_i = a; line_wdata_i = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (line_resp_o !== 1'b1 && lat < 300);
    if (line_resp_o !== 1'b1) chk("resp_timeout", 256'(line_resp_o), 256'(1));
    if (!hold) begin line_read_i = 1'b0; line_write_i = 1'b0; end
  endtask

  localparam logic [255:0] PAT_LINE = {64'h4444444444444444, 64'h3333333333333333,
                                       64'h2222222222222222, 64'h1111111111111111};

  initial begin
    int lat, seen;
    logic [255:0] d;
    rst_n = 1'b0; line_read_i = 1'b0; line_write_i = 1'b0;
    line_addr_i = '0; line_wdata_i = '0; pmem_resp_i = 1'b0; pmem_rdata_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdata",   line_rdata_o, '0);
    chk("reset_strobes", 256'({pmem_read_o, pmem_write_o, line_resp_o}), '0);
    chk("reset_addr",    256'(pmem_addr_o), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // read, zero wait
    pat = 1'b1; wait_n = 0;
    req(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0, lat);
    chk("rd_latency", 256'(lat), 256'(5));
    chk("rd_line",    line_rdata_o, PAT_LINE);
    chk("rd_addr",    256'(pmem_addr_o), 256'(32'h0000_1220));
    @(negedge clk);

    // write, resp every 3rd cycle
    pat = 1'b0; wait_n = 3; d = rand256();
    req(1'b0, 1'b1, 32'h0000_2a5f, d, 1'b0, lat);
    chk("wr_latency",     256'(lat), 256'(13));
    chk("wr_keeps_rdata", line_rdata_o, PAT_LINE);
    chk("wr_addr",        256'(pmem_addr_o), 256'(32'h0000_2a40));
    @(negedge clk);

    // read held through DONE and one cycle after
    wait_n = 0;
    req(1'b1, 1'b0, 32'h0000_3000, '0, 1'b1, lat);
    @(negedge clk);
    chk("no_burst_in_done", 256'(pmem_read_o), 256'(0));
    @(negedge clk);
    chk("burst_after_done", 256'(pmem_read_o), 256'(1));
    req(1'b1, 1'b0, 32'h0000_3000, '0, 1'b0, lat);
    chk("second_burst_lat", 256'(lat), 256'(4));
    @(negedge clk);

    // simultaneous strobes: read wins
    line_read_i = 1'b1; line_write_i = 1'b1; line_addr_i = 32'h8000_0040; line_wdata_i = rand256();
    @(negedge clk);
    chk("both_read",  256'(pmem_read_o),  256'(1));
    chk("both_write", 256'(pmem_write_o), 256'(0));
    chk("both_addr",  256'(pmem_addr_o),  256'(32'h8000_0040));
    req(1'b1, 1'b1, 32'h8000_0040, line_wdata_i, 1'b0, lat);
    @(negedge clk);

    // reset after two read beats
    pat = 1'b1;
    line_read_i = 1'b1; line_addr_i = 32'h0000_5555;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; line_read_i = 1'b0;
    @(negedge clk);
    chk("midrst_strobes", 256'({pmem_read_o, pmem_write_o, line_resp_o}), '0);
    chk("midrst_rdata",   line_rdata_o, '0);
    rst_n = 1'b1; pat = 1'b0;
    @(negedge clk);
    req(1'b1, 1'b0, 32'h0000_5555, '0, 1'b0, lat);
    chk("post_rst_lat", 256'(lat), 256'(5));
    @(negedge clk);

    // stray resp in IDLE
    stray = 1'b1; seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (line_resp_o === 1'b1) seen++;
    end
    chk("stray_no_resp", 256'(seen), '0);
    chk("stray_idle",    256'({pmem_read_o, pmem_write_o}), '0);
    stray = 1'b0;

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit rd, wr;
      int sel;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      wait_n = (sel == 3) ? -1 : sel;
      if (rd || wr) req(rd, wr, $urandom, rand256(), 1'b0, lat);
      stray = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      stray = 1'b0;
    end
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_chk - n_fail, n_chk);
    $fatal(1);
  end

endmodule
